// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID decoupling queue.
// The queue takes the slave side; fetch and decode together form the master side.
interface if_id_queue_if #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
);
  localparam int LW = $clog2(DEPTH) + 1;

  // Fetch side
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            in_ready;

  // Decode side
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_ready;

  // Redirect and status
  logic            flush;
  logic [LW-1:0]   level;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, level
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, level
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a first-word-fall-through FIFO of {pc, instr} pairs.
// Absorbs decode stalls, preserves fetch order and drops everything on flush.
// No bypass: a word pushed at edge N is first visible after edge N.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  if_id_queue_if.slave    q
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;

  logic   in_ready;
  logic   out_valid;
  logic   push;
  logic   pop;
  entry_t head;

  // Handshake qualifiers; in_ready deliberately ignores out_ready so there is
  // no combinational path from decode back to fetch.
  assign in_ready  = !reset && (level_q != LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = q.in_valid && in_ready;
  assign pop       = out_valid && q.out_ready;
  assign head      = mem_q[rptr_q];

  assign q.in_ready  = in_ready;
  assign q.out_valid = out_valid;
  assign q.out_pc    = out_valid ? head.pc    : '0;
  assign q.out_instr = out_valid ? head.instr : '0;
  assign q.level     = level_q;

  // Next-state for pointers and occupancy; flush overrides any push or pop.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (q.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  // Control state: cleared asynchronously so the queue empties the instant reset rises.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Entry storage; a word pushed in a flush cycle is not written.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; stale entries are unreachable because out_valid masks the read.
    if (push && !q.flush) mem_q[wptr_q] <= entry_t'({q.in_pc, q.in_instr});
  end

  // Occupancy never exceeds the number of entries.
  a_level_max : assert property (@(posedge clk) disable iff (reset)
    level_q <= LW'(DEPTH));

  // Pointer distance tracks occupancy modulo DEPTH (full means equal pointers).
  a_ptr_track : assert property (@(posedge clk) disable iff (reset)
    PW'(wptr_q - rptr_q) == level_q[PW-1:0]);

  // A word offered while not ready never raises occupancy.
  a_no_push_full : assert property (@(posedge clk) disable iff (reset)
    !in_ready |-> (level_d <= level_q));
endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: a DEPTH=2 and a DEPTH=4 instance, each tracked by a
// queue-based model and compared on every falling edge, plus directed scenarios
// with literal expectations and a randomized soak.
module tb_if_id_queue;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_id_queue_if #(.DEPTH(2), .XLEN(32)) if2 ();
  if_id_queue_if #(.DEPTH(4), .XLEN(32)) if4 ();

  if_id_queue #(.DEPTH(2), .XLEN(32)) dut2 (.clk(clk), .reset(reset), .q(if2.slave));
  if_id_queue #(.DEPTH(4), .XLEN(32)) dut4 (.clk(clk), .reset(reset), .q(if4.slave));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference models: ordered lists of held words, updated from the inputs only.
  entry_t m2[$];
  entry_t m4[$];
  bit p2, o2, p4, o4;

  always @(posedge clk or posedge reset) begin
    if (reset) m2.delete();
    else begin
      p2 = if2.in_valid && (m2.size() != 2);
      o2 = if2.out_ready && (m2.size() != 0);
      if (if2.flush) m2.delete();
      else begin
        if (o2) void'(m2.pop_front());
        if (p2) m2.push_back(entry_t'({if2.in_pc, if2.in_instr}));
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) m4.delete();
    else begin
      p4 = if4.in_valid && (m4.size() != 4);
      o4 = if4.out_ready && (m4.size() != 0);
      if (if4.flush) m4.delete();
      else begin
        if (o4) void'(m4.pop_front());
        if (p4) m4.push_back(entry_t'({if4.in_pc, if4.in_instr}));
      end
    end
  end

  task automatic cmp(input string tag, input int depth, input int sz, input entry_t head,
                     input logic ov, input logic ir, input logic [31:0] opc,
                     input logic [31:0] oin, input logic [31:0] lvl);
    bit v;
    v = (sz != 0);
    check({tag, ".out_valid"}, 64'(ov), 64'(v));
    check({tag, ".in_ready"},  64'(ir), 64'(!reset && (sz != depth)));
    check({tag, ".out_pc"},    64'(opc), v ? 64'(head.pc) : 64'd0);
    check({tag, ".out_instr"}, 64'(oin), v ? 64'(head.instr) : 64'd0);
    check({tag, ".level"},     64'(lvl), 64'(sz));
  endtask

  // Every-cycle comparison against the models, away from the active edge.
  always @(negedge clk) begin
    cmp("m2", 2, m2.size(), (m2.size() != 0) ? m2[0] : '0, if2.out_valid, if2.in_ready,
        if2.out_pc, if2.out_instr, 32'(if2.level));
    cmp("m4", 4, m4.size(), (m4.size() != 0) ? m4[0] : '0, if4.out_valid, if4.in_ready,
        if4.out_pc, if4.out_instr, 32'(if4.level));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] t1_instr [4];
  int next_pc, exp_out, cyc;
  bit acc;

  initial begin
    t1_instr[0] = 32'h0000_0013;
    t1_instr[1] = 32'h0050_0093;
    t1_instr[2] = 32'h00A0_0113;
    t1_instr[3] = 32'h0020_81B3;

    reset = 1'b1;
    if2.in_valid = 0; if2.in_pc = 0; if2.in_instr = 0; if2.out_ready = 0; if2.flush = 0;
    if4.in_valid = 0; if4.in_pc = 0; if4.in_instr = 0; if4.out_ready = 0; if4.flush = 0;
    #1;
    check("reset.out_valid", 64'(if2.out_valid), 64'd0);
    check("reset.in_ready",  64'(if2.in_ready),  64'd0);
    check("reset.level",     64'(if2.level),     64'd0);
    check("reset.out_pc",    64'(if2.out_pc),    64'd0);
    step(); step();
    reset = 1'b0;
    #1;
    check("release.in_ready", 64'(if2.in_ready), 64'd1);
    step();

    // Alternate push / idle with decode always ready: level 1,0,1,0...
    if2.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if2.in_valid = 1; if2.in_pc = 32'(i); if2.in_instr = t1_instr[i];
      step();
      if2.in_valid = 0;
      check("stream.out_valid", 64'(if2.out_valid), 64'd1);
      check("stream.out_pc",    64'(if2.out_pc),    64'(i));
      check("stream.out_instr", 64'(if2.out_instr), 64'(t1_instr[i]));
      check("stream.level1",    64'(if2.level),     64'd1);
      step();
      check("stream.level0",    64'(if2.level),     64'd0);
    end

    // Fill a DEPTH=2 queue and hold PC 2 while full.
    if2.out_ready = 0;
    if2.in_valid = 1; if2.in_pc = 0; if2.in_instr = 32'h10; step();
    if2.in_pc = 1; if2.in_instr = 32'h11; step();
    if2.in_pc = 2; if2.in_instr = 32'h12;
    check("full.level",    64'(if2.level),    64'd2);
    check("full.in_ready", 64'(if2.in_ready), 64'd0);
    step();
    check("full.hold_level", 64'(if2.level),  64'd2);
    check("full.head",       64'(if2.out_pc), 64'd0);
    if2.out_ready = 1; step();
    if2.out_ready = 0;
    check("full.pop_head",  64'(if2.out_pc),   64'd1);
    check("full.reopened",  64'(if2.in_ready), 64'd1);
    check("full.pop_level", 64'(if2.level),    64'd1);
    step();
    if2.in_valid = 0;
    check("full.accept_level", 64'(if2.level), 64'd2);
    if2.out_ready = 1; step();
    check("full.order2", 64'(if2.out_pc), 64'd2);
    step();
    check("full.drained", 64'(if2.level), 64'd0);

    // Simultaneous push and pop at level 1.
    if2.out_ready = 0; if2.in_valid = 1; if2.in_pc = 5; if2.in_instr = 32'h55; step();
    check("pushpop.pre_level", 64'(if2.level), 64'd1);
    if2.out_ready = 1; if2.in_pc = 6; if2.in_instr = 32'h66; step();
    if2.in_valid = 0;
    check("pushpop.level",  64'(if2.level),  64'd1);
    check("pushpop.out_pc", 64'(if2.out_pc), 64'd6);
    step();
    check("pushpop.drained", 64'(if2.level), 64'd0);

    // Flush while full with a word offered.
    if2.out_ready = 0; if2.in_valid = 1; if2.in_pc = 8; if2.in_instr = 32'h88; step();
    if2.in_pc = 9; if2.in_instr = 32'h99; step();
    check("flush.pre_level", 64'(if2.level), 64'd2);
    if2.flush = 1; if2.in_pc = 10; if2.in_instr = 32'hAA;
    check("flush.in_ready_full", 64'(if2.in_ready), 64'd0);
    step();
    if2.flush = 0; if2.in_valid = 0;
    check("flush.level",     64'(if2.level),     64'd0);
    check("flush.out_valid", 64'(if2.out_valid), 64'd0);
    check("flush.out_pc",    64'(if2.out_pc),    64'd0);
    check("flush.in_ready",  64'(if2.in_ready),  64'd1);
    step();
    check("flush.not_stored", 64'(if2.level), 64'd0);

    // Flush at level 1 with a push and pop in the same cycle: both discarded.
    if2.in_valid = 1; if2.in_pc = 11; if2.in_instr = 32'hBB; step();
    if2.flush = 1; if2.out_ready = 1; if2.in_pc = 12; if2.in_instr = 32'hCC;
    check("flush2.in_ready", 64'(if2.in_ready), 64'd1);
    step();
    if2.flush = 0; if2.in_valid = 0; if2.out_ready = 0;
    check("flush2.level",     64'(if2.level),     64'd0);
    check("flush2.out_valid", 64'(if2.out_valid), 64'd0);

    // Twenty PCs through DEPTH=4 with random decode stalls; order across wrap.
    next_pc = 0; exp_out = 0; cyc = 0;
    while (exp_out < 20 && cyc < 1000) begin
      if4.in_valid  = (next_pc < 20);
      if4.in_pc     = 32'(next_pc);
      if4.in_instr  = 32'(next_pc) ^ 32'hA5A5_0000;
      if4.out_ready = 1'($urandom_range(0, 1));
      acc = if4.in_valid && if4.in_ready;
      if (if4.out_valid && if4.out_ready) begin
        check("wrap.order", 64'(if4.out_pc), 64'(exp_out));
        exp_out++;
      end
      step();
      if (acc) next_pc++;
      cyc++;
    end
    check("wrap.all_out", 64'(exp_out), 64'd20);
    if4.in_valid = 0; if4.out_ready = 0;
    step();

    // Asynchronous reset mid-cycle at level 3.
    for (int i = 0; i < 3; i++) begin
      if4.in_valid = 1; if4.in_pc = 32'(100 + i); if4.in_instr = 32'(i); step();
    end
    if4.in_valid = 0;
    check("areset.pre_level", 64'(if4.level), 64'd3);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset.out_valid", 64'(if4.out_valid), 64'd0);
    check("areset.level",     64'(if4.level),     64'd0);
    check("areset.in_ready",  64'(if4.in_ready),  64'd0);
    check("areset.out_pc",    64'(if4.out_pc),    64'd0);
    step();
    reset = 1'b0;
    #1;
    check("areset.release_ready", 64'(if4.in_ready), 64'd1);
    if4.in_valid = 1; if4.in_pc = 0; if4.in_instr = 32'h13;
    step();
    if4.in_valid = 0;
    check("areset.push_pc",    64'(if4.out_pc),    64'd0);
    check("areset.push_valid", 64'(if4.out_valid), 64'd1);
    check("areset.push_level", 64'(if4.level),     64'd1);

    // Randomized soak on both depths, including flushes.
    for (int i = 0; i < 400; i++) begin
      if2.in_valid  = ($urandom_range(0, 3) != 0);
      if2.in_pc     = $urandom;
      if2.in_instr  = $urandom;
      if2.out_ready = 1'($urandom_range(0, 1));
      if2.flush     = ($urandom_range(0, 19) == 0);
      if4.in_valid  = ($urandom_range(0, 3) != 0);
      if4.in_pc     = $urandom;
      if4.in_instr  = $urandom;
      if4.out_ready = ($urandom_range(0, 2) == 0);
      if4.flush     = ($urandom_range(0, 19) == 0);
      step();
    end
    if2.in_valid = 0; if2.out_ready = 0; if2.flush = 0;
    if4.in_valid = 0; if4.out_ready = 0; if4.flush = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
